// File: rtl/scrypt_nonce_sched_if.sv
// Job, core and result signals of the nonce scheduler.
// The scheduler uses the slave modport; the host/core side uses master.
interface scrypt_nonce_sched_if #(
  parameter int HDR_W = 640
);
  logic             job_valid;
  logic             job_ready;
  logic [HDR_W-1:0] job_header;
  logic [31:0]      job_start;
  logic [31:0]      job_end;
  logic             abort;
  logic             core_enable;
  logic [HDR_W-1:0] core_data;
  logic             core_hash_done;
  logic             core_match_found;
  logic             found_valid;
  logic [31:0]      found_nonce;
  logic             found_ack;
  logic             done;
  logic             fault;
  logic [31:0]      hash_count;

  modport master (
    output job_valid, job_header, job_start, job_end, abort,
           core_hash_done, core_match_found, found_ack,
    input  job_ready, core_enable, core_data, found_valid, found_nonce,
           done, fault, hash_count
  );

  modport slave (
    input  job_valid, job_header, job_start, job_end, abort,
           core_hash_done, core_match_found, found_ack,
    output job_ready, core_enable, core_data, found_valid, found_nonce,
           done, fault, hash_count
  );
endinterface

// File: rtl/scrypt_nonce_sched.sv
// Sequences one scrypt core across an inclusive, wrapping nonce range,
// reporting matches with a hold-until-ack handshake plus done/fault status.
module scrypt_nonce_sched #(
  parameter int HDR_W     = 640,
  parameter int NONCE_LSB = 608,
  parameter int TIMEOUT   = 2**20
) (
  input logic                 clk,
  input logic                 rst,
  scrypt_nonce_sched_if.slave bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  // Last watchdog value before the fault fires: fault appears TIMEOUT cycles after ISSUE.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FOUND,
    S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [HDR_W-1:0] header_reg, header_next;
  logic [HDR_W-1:0] core_data_reg, core_data_next;
  logic [31:0]      cur_nonce_reg, cur_nonce_next;
  logic [31:0]      end_reg, end_next;
  logic [31:0]      hash_count_reg, hash_count_next;
  logic [31:0]      found_nonce_reg, found_nonce_next;
  logic             fault_reg, fault_next;
  logic [WD_W-1:0]  wdog_reg, wdog_next;
  logic             step;

  always_comb begin
    state_next       = state_reg;
    header_next      = header_reg;
    cur_nonce_next   = cur_nonce_reg;
    end_next         = end_reg;
    hash_count_next  = hash_count_reg;
    found_nonce_next = found_nonce_reg;
    fault_next       = fault_reg;
    wdog_next        = wdog_reg;
    step             = 1'b0;

    if (bus.abort && state_reg != S_IDLE) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.job_valid) begin
            header_next     = bus.job_header;
            cur_nonce_next  = bus.job_start;
            end_next        = bus.job_end;
            hash_count_next = 32'd0;
            fault_next      = 1'b0;
            state_next      = S_ISSUE;
          end
        end
        S_ISSUE: begin
          wdog_next  = '0;
          state_next = S_WAIT;
        end
        S_WAIT: begin
          wdog_next = wdog_reg + 1'b1;
          if (bus.core_hash_done) begin
            hash_count_next = hash_count_reg + 32'd1;
            if (bus.core_match_found) begin
              found_nonce_next = cur_nonce_reg;
              state_next       = S_FOUND;
            end else begin
              step = 1'b1;
            end
          end else if (wdog_reg == WD_LAST) begin
            fault_next = 1'b1;
            state_next = S_IDLE;
          end
        end
        S_FOUND: begin
          if (bus.found_ack) begin
            step = 1'b1;
          end
        end
        S_DONE: begin
          state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase

      // Range end is checked by nonce equality so a full 2^32 sweep terminates.
      if (step) begin
        if (cur_nonce_reg == end_reg) begin
          state_next = S_DONE;
        end else begin
          cur_nonce_next = cur_nonce_reg + 32'd1;
          state_next     = S_ISSUE;
        end
      end
    end

    core_data_next = core_data_reg;
    if (state_next == S_ISSUE) begin
      core_data_next                    = header_next;
      core_data_next[NONCE_LSB +: 32]   = cur_nonce_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      header_reg      <= '0;
      core_data_reg   <= '0;
      cur_nonce_reg   <= 32'd0;
      end_reg         <= 32'd0;
      hash_count_reg  <= 32'd0;
      found_nonce_reg <= 32'd0;
      fault_reg       <= 1'b0;
      wdog_reg        <= '0;
    end else begin
      state_reg       <= state_next;
      header_reg      <= header_next;
      core_data_reg   <= core_data_next;
      cur_nonce_reg   <= cur_nonce_next;
      end_reg         <= end_next;
      hash_count_reg  <= hash_count_next;
      found_nonce_reg <= found_nonce_next;
      fault_reg       <= fault_next;
      wdog_reg        <= wdog_next;
    end
  end

  assign bus.job_ready   = (state_reg == S_IDLE);
  assign bus.core_enable = (state_reg == S_ISSUE);
  assign bus.core_data   = core_data_reg;
  assign bus.found_valid = (state_reg == S_FOUND);
  assign bus.found_nonce = found_nonce_reg;
  assign bus.done        = (state_reg == S_DONE);
  assign bus.fault       = fault_reg;
  assign bus.hash_count  = hash_count_reg;

endmodule

// File: tb/tb_scrypt_nonce_sched.sv
// Directed bench for scrypt_nonce_sched with a fixed-latency core model.
module tb_scrypt_nonce_sched;
  localparam int HDR_W = 640;
  localparam int NL    = 608;
  localparam int LAT   = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scrypt_nonce_sched_if #(.HDR_W(HDR_W)) bus ();

  scrypt_nonce_sched #(
    .HDR_W    (HDR_W),
    .NONCE_LSB(NL),
    .TIMEOUT  (64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Core model and monitors, updated on the falling edge.
  logic        model_on   = 1'b1;
  logic        model_hang = 1'b0;
  logic        match_en   = 1'b0;
  logic [31:0] match_nonce = 32'd0;
  logic        m_done = 1'b0, m_match = 1'b0;
  logic        d_done = 1'b0, d_match = 1'b0;
  logic [31:0] m_nonce = 32'd0;
  int          m_cnt = 0;
  int          cyc = 0;
  int          en_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] nlog [0:127];

  assign bus.core_hash_done   = model_on ? m_done  : d_done;
  assign bus.core_match_found = model_on ? m_match : d_match;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.done) done_cnt = done_cnt + 1;
    m_done  = 1'b0;
    m_match = 1'b0;
    if (bus.core_enable) begin
      nlog[en_cnt & 127] = bus.core_data[NL +: 32];
      en_cnt = en_cnt + 1;
      if (!model_hang) begin
        m_cnt   = LAT;
        m_nonce = bus.core_data[NL +: 32];
      end
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_done  = 1'b1;
        m_match = match_en && (m_nonce == match_nonce);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [HDR_W-1:0] hdr, input logic [31:0] s, input logic [31:0] e);
    bus.job_valid  = 1'b1;
    bus.job_header = hdr;
    bus.job_start  = s;
    bus.job_end    = e;
    tick();
    bus.job_valid  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int   n    = 0;
    logic seen = 1'b0;
    while (!seen && n < budget) begin
      tick();
      n++;
      if (bus.done) seen = 1'b1;
    end
    check("done_within_budget", 64'(seen), 64'd1);
  endtask

  task automatic wait_found(input int budget);
    int   n    = 0;
    logic seen = 1'b0;
    while (!seen && n < budget) begin
      tick();
      n++;
      if (bus.found_valid) seen = 1'b1;
    end
    check("found_within_budget", 64'(seen), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: observed=expired expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [HDR_W-1:0] hdr;
    int base, dbase, t_issue, n, hc_snap, e_snap, d_snap;

    hdr = {20{32'hDEADBEEF}};
    bus.job_valid  = 1'b0;
    bus.job_header = '0;
    bus.job_start  = 32'd0;
    bus.job_end    = 32'd0;
    bus.abort      = 1'b0;
    bus.found_ack  = 1'b0;

    // Reset state
    tick(3);
    check("rst_job_ready", 64'(bus.job_ready), 64'd1);
    check("rst_core_enable", 64'(bus.core_enable), 64'd0);
    check("rst_found_valid", 64'(bus.found_valid), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_fault", 64'(bus.fault), 64'd0);
    check("rst_found_nonce", 64'(bus.found_nonce), 64'd0);
    check("rst_hash_count", 64'(bus.hash_count), 64'd0);
    check("rst_core_data_or", 64'(|bus.core_data), 64'd0);
    rst = 1'b0;
    tick();

    // Job 5..7, no match
    base = en_cnt; dbase = done_cnt;
    start_job(hdr, 32'd5, 32'd7);
    wait_done(200);
    check("j1_enables", 64'(en_cnt - base), 64'd3);
    check("j1_nonce0", 64'(nlog[base & 127]), 64'd5);
    check("j1_nonce1", 64'(nlog[(base + 1) & 127]), 64'd6);
    check("j1_nonce2", 64'(nlog[(base + 2) & 127]), 64'd7);
    check("j1_hash_count", 64'(bus.hash_count), 64'd3);
    check("j1_header_kept", 64'(bus.core_data[607:576]), 64'hDEADBEEF);
    tick();
    check("j1_done_pulses", 64'(done_cnt - dbase), 64'd1);
    check("j1_job_ready", 64'(bus.job_ready), 64'd1);
    check("j1_done_low", 64'(bus.done), 64'd0);
    $display("job 5..7 hashes=%0d", bus.hash_count);

    // Job 0x10..0x20 with a match on 0x13
    base = en_cnt; dbase = done_cnt;
    match_en = 1'b1; match_nonce = 32'h13;
    start_job(hdr, 32'h10, 32'h20);
    wait_found(300);
    check("j2_found_nonce", 64'(bus.found_nonce), 64'h13);
    check("j2_enables_at_found", 64'(en_cnt - base), 64'd4);
    e_snap = en_cnt;
    tick(50);
    check("j2_found_held", 64'(bus.found_valid), 64'd1);
    check("j2_no_enable_while_held", 64'(en_cnt - e_snap), 64'd0);
    check("j2_found_nonce_stable", 64'(bus.found_nonce), 64'h13);
    bus.found_ack = 1'b1;
    tick();
    bus.found_ack = 1'b0;
    match_en = 1'b0;
    check("j2_found_cleared", 64'(bus.found_valid), 64'd0);
    wait_done(600);
    check("j2_resume_nonce", 64'(nlog[(base + 4) & 127]), 64'h14);
    check("j2_last_nonce", 64'(nlog[(base + 16) & 127]), 64'h20);
    check("j2_enables", 64'(en_cnt - base), 64'd17);
    check("j2_hash_count", 64'(bus.hash_count), 64'd17);
    tick();
    check("j2_done_pulses", 64'(done_cnt - dbase), 64'd1);
    $display("job 10..20 found=13 hashes=%0d", bus.hash_count);

    // Wrapping range
    base = en_cnt;
    start_job(hdr, 32'hFFFFFFFE, 32'h1);
    wait_done(200);
    check("wrap_n0", 64'(nlog[base & 127]), 64'hFFFFFFFE);
    check("wrap_n1", 64'(nlog[(base + 1) & 127]), 64'hFFFFFFFF);
    check("wrap_n2", 64'(nlog[(base + 2) & 127]), 64'h0);
    check("wrap_n3", 64'(nlog[(base + 3) & 127]), 64'h1);
    check("wrap_hash_count", 64'(bus.hash_count), 64'd4);
    tick();
    $display("job fffffffe..1 hashes=%0d", bus.hash_count);

    // Core timeout
    model_hang = 1'b1;
    dbase = done_cnt;
    start_job(hdr, 32'h100, 32'h100);
    check("to_issue_seen", 64'(bus.core_enable), 64'd1);
    t_issue = cyc;
    n = 0;
    while (!bus.fault && n < 200) begin
      tick();
      n++;
    end
    check("to_fault_delay", 64'(cyc - t_issue), 64'd64);
    check("to_idle", 64'(bus.job_ready), 64'd1);
    tick(3);
    check("to_fault_sticky", 64'(bus.fault), 64'd1);
    check("to_no_done", 64'(done_cnt - dbase), 64'd0);
    model_hang = 1'b0;
    start_job(hdr, 32'h9, 32'h9);
    check("to_fault_cleared", 64'(bus.fault), 64'd0);
    wait_done(100);
    check("single_hash_count", 64'(bus.hash_count), 64'd1);
    tick();
    $display("job 100 timeout, job 9..9 hashes=%0d", bus.hash_count);

    // Abort coincident with a matching hash_done
    model_on = 1'b0; model_hang = 1'b1;
    dbase = done_cnt;
    start_job(hdr, 32'h40, 32'h50);
    tick(5);
    bus.abort = 1'b1; d_done = 1'b1; d_match = 1'b1;
    tick();
    bus.abort = 1'b0; d_done = 1'b0; d_match = 1'b0;
    check("ab_idle", 64'(bus.job_ready), 64'd1);
    check("ab_found_low", 64'(bus.found_valid), 64'd0);
    hc_snap = bus.hash_count; e_snap = en_cnt; d_snap = done_cnt;
    tick(3);
    d_done = 1'b1; d_match = 1'b1;
    tick();
    d_done = 1'b0; d_match = 1'b0;
    tick(3);
    check("ab_late_found_low", 64'(bus.found_valid), 64'd0);
    check("ab_late_hash_count", 64'(bus.hash_count), 64'(hc_snap));
    check("ab_no_enable", 64'(en_cnt - e_snap), 64'd0);
    check("ab_no_done", 64'(done_cnt - dbase), 64'd0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("ab_idle_abort_noop", 64'(bus.job_ready), 64'd1);
    check("ab_idle_no_done", 64'(done_cnt - d_snap), 64'd0);
    $display("job 40..50 aborted hashes=%0d", bus.hash_count);

    // Reset during FOUND; job_valid held through reset
    model_on = 1'b1; model_hang = 1'b0;
    match_en = 1'b1; match_nonce = 32'h60;
    start_job(hdr, 32'h60, 32'h61);
    wait_found(100);
    rst = 1'b1;
    bus.job_valid = 1'b1; bus.job_start = 32'h70; bus.job_end = 32'h70;
    tick();
    check("rf_found_valid", 64'(bus.found_valid), 64'd0);
    check("rf_found_nonce", 64'(bus.found_nonce), 64'd0);
    check("rf_hash_count", 64'(bus.hash_count), 64'd0);
    check("rf_core_data_or", 64'(|bus.core_data), 64'd0);
    check("rf_job_ready", 64'(bus.job_ready), 64'd1);
    tick();
    check("rf_not_accepted_in_rst", 64'(bus.core_enable), 64'd0);
    rst = 1'b0;
    match_en = 1'b0;
    tick();
    bus.job_valid = 1'b0;
    check("rf_accept_after_rst", 64'(bus.core_enable), 64'd1);
    check("rf_nonce", 64'(bus.core_data[NL +: 32]), 64'h70);
    wait_done(100);
    check("rf_hash_count_final", 64'(bus.hash_count), 64'd1);
    tick();
    $display("job 70..70 after reset hashes=%0d", bus.hash_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/scrypt_nonce_sched.md
Name: scrypt_nonce_sched

Overview:
- Job-level controller that sequences one scrypt_top core across a nonce range.
- Accepts a 640-bit block header plus a start/end nonce, then runs the core once per nonce.
- For each hash: splices the nonce into the header, pulses the core's enable, waits for hash_done and samples match_found.
- Reports matches with a hold-until-ack handshake, and flags range exhaustion, abort and core timeout.

Parameters:
- HDR_W, 640, header width; matches the scrypt_top data port.
- NONCE_LSB, 608, LSB of the 32-bit nonce field in the header (bits [NONCE_LSB+31:NONCE_LSB]).
- TIMEOUT, 2**20, maximum cycles in WAIT before declaring a core fault.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- job_valid  in  1  job offered
- job_ready  out  1  controller idle and able to accept a job
- job_header  in  HDR_W  header template; its nonce field is ignored
- job_start  in  32  first nonce
- job_end  in  32  last nonce, inclusive, modulo 2^32
- abort  in  1  cancel the current job
- core_enable  out  1  one-cycle start pulse to scrypt_top
- core_data  out  HDR_W  header with the current nonce spliced in
- core_hash_done  in  1  core finished the current hash
- core_match_found  in  1  qualified by core_hash_done
- found_valid  out  1  a matching nonce is available
- found_nonce  out  32  the matching nonce
- found_ack  in  1  consumer accepts found_nonce
- done  out  1  one-cycle pulse: range exhausted
- fault  out  1  sticky core timeout flag
- hash_count  out  32  hashes completed in the current job

Behaviour:
- Reset: state IDLE.
  - job_ready=1.
  - core_enable=0, found_valid=0, done=0, fault=0.
  - found_nonce=0, hash_count=0, core_data=0.
  - rst overrides everything, including mid-hash; the core is reset separately by its owner.
- IDLE: job_ready=1.
  - On job_valid at cycle T: capture header/start/end, set cur_nonce=job_start, clear hash_count and fault; go to ISSUE at T+1.
- ISSUE (1 cycle): core_enable=1, core_data valid; watchdog cleared; go to WAIT.
  - core_data is registered and stable from ISSUE through the end of WAIT.
- WAIT: watchdog increments every cycle.
  - On core_hash_done: hash_count+1.
    - If core_match_found: go to FOUND; found_nonce=cur_nonce; found_valid=1 next cycle.
    - Else if cur_nonce==end: go to DONE.
    - Else: cur_nonce+1 (wraps FFFFFFFF->0); go to ISSUE.
  - Watchdog reaching TIMEOUT-1 without core_hash_done: fault=1, go to IDLE; fault stays set until the next job accept or rst.
- FOUND: found_valid=1, found_nonce stable.
  - On found_ack: found_valid=0 next cycle; then same end-check as a non-match (DONE or increment+ISSUE).
  - Search is suspended while unacked; the core stays idle.
- DONE (1 cycle): done=1; go to IDLE.
- Throughput: one hash per (core latency + 2) cycles (ISSUE, plus the cycle that processes hash_done).
- Boundaries:
  - job_start==job_end: exactly one hash.
  - start>end: range wraps through 0.
  - 0..FFFFFFFF: 2^32 hashes; hash_count wraps to 0 on the last hash and is not used for termination.
- abort: in any non-IDLE state, go to IDLE next cycle.
  - found_valid=0 and no done pulse; hash_count is kept.
  - core_hash_done arriving in IDLE is ignored.
  - abort in IDLE has no effect.
- Simultaneous events:
  - abort and core_hash_done in the same cycle: abort wins; no found_valid is raised.
  - abort and found_ack in the same cycle: abort wins.
- job_valid is ignored unless in IDLE.
- core_match_found is ignored when core_hash_done=0.

Test Plan:
- Reset then job start=5, end=7, core model done after 20 cycles, never matching -> 3 core_enable pulses, with core_data[639:608] = 5, 6, 7; done pulses once; hash_count=3; job_ready returns.
- Job 0x10..0x20, core matches on nonce 0x13 -> found_valid with found_nonce=0x13, held 50 cycles with no core_enable until found_ack; search then resumes at 0x14 and ends with done, hash_count=17.
- Wrap: start=FFFFFFFE, end=1 -> nonces FFFFFFFE, FFFFFFFF, 0, 1 in order; done; hash_count=4.
- Core never asserts hash_done, TIMEOUT overridden to 64 -> fault=1 exactly 64 cycles after ISSUE; state IDLE; fault clears on the next job accept.
- abort asserted mid-WAIT on the same cycle as core_hash_done with a match -> IDLE next cycle; found_valid stays 0; no done pulse; a late hash_done is ignored.
- rst asserted during FOUND -> all outputs return to reset values next cycle; job_valid held high during rst is not accepted until the cycle after rst deasserts.
